// File: rtl/interrupt_controller_if.sv
// I/O bus and CPU interrupt handshake bundle for interrupt_controller.
// irq_req/irq_ack: the request is held until the cycle irq_ack is sampled high, then drops next cycle.
interface interrupt_controller_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic       irq_ack;
  logic       irq_done;
  logic       irq_req;
  logic [2:0] irq_vector;
  logic [1:0] state_dbg;

  modport master (
    output din, address, w_en, r_en, irq_ack, irq_done,
    input  dout, irq_req, irq_vector, state_dbg
  );

  modport slave (
    input  din, address, w_en, r_en, irq_ack, irq_done,
    output dout, irq_req, irq_vector, state_dbg
  );
endinterface

// File: rtl/interrupt_controller.sv
// Eight-source edge-triggered interrupt controller with a 5-register I/O window,
// fixed priority (bit 0 highest) and a single non-nesting IDLE/REQ/SERVICE handshake.
module interrupt_controller #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            irq_in,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic       gie;
  logic [7:0] enable;
  logic [7:0] pending;
  logic [7:0] pending_next;
  logic [7:0] prev;
  logic [7:0] dout_q;
  logic [2:0] vec;
  logic [2:0] pick;
  logic [7:0] pend_en;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] rd_data;
  logic [7:0] offset;
  logic       hit;
  logic       latch_vec;
  logic       ack_take;

  // Wrapping subtraction keeps the window decode a single compare.
  assign offset  = bus.address - BASE_ADDR;
  assign hit     = (offset < 8'd5);
  assign pend_en = pending & enable;

  always_comb begin
    pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_en[i]) pick = 3'(i);
    end
  end

  always_comb begin
    state_next = state;
    latch_vec  = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (gie && (pend_en != 8'h00)) begin
          state_next = REQ;
          latch_vec  = 1'b1;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_next = SERVICE;
          ack_take   = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.irq_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sets are OR-ed in after clears so a same-cycle set always wins.
  always_comb begin
    set_mask = irq_in & ~prev;
    clr_mask = 8'h00;
    if (bus.w_en && hit && offset[2:0] == 3'd4) set_mask = set_mask | bus.din;
    if (bus.w_en && hit && offset[2:0] == 3'd2) clr_mask = bus.din;
    if (ack_take) clr_mask = clr_mask | (8'h01 << vec);
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  always_comb begin
    rd_data = 8'h00;
    case (offset[2:0])
      3'd0:    rd_data = {7'b0, gie};
      3'd1:    rd_data = enable;
      3'd2:    rd_data = pending;
      3'd3:    rd_data = {(state == SERVICE), 4'b0, vec};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    prev <= irq_in;
    if (rst) begin
      gie     <= 1'b0;
      enable  <= 8'h00;
      pending <= 8'h00;
      vec     <= 3'd0;
      dout_q  <= 8'h00;
    end else begin
      pending <= pending_next;
      if (bus.w_en && hit && offset[2:0] == 3'd0) gie    <= bus.din[0];
      if (bus.w_en && hit && offset[2:0] == 3'd1) enable <= bus.din;
      if (latch_vec) vec <= pick;
      if (bus.r_en && hit) dout_q <= rd_data;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.irq_req    = (state == REQ);
  assign bus.irq_vector = (state == REQ) ? vec : 3'd0;
  assign bus.state_dbg  = state;

endmodule
